// File: rtl/mux_out_edge_monitor_pkg.sv
// Shared types and defaults for the out_q edge monitor.
// Pure declarations: no latency, no flow control.
package mux_mon_pkg;
   typedef enum logic [1:0] {
      DEB_LOW,
      DEB_CHK_HIGH,
      DEB_HIGH,
      DEB_CHK_LOW
   } deb_state_e;

   localparam int STABLE_CYCLES_DEF = 4;
   localparam int CNT_WIDTH_DEF     = 8;
endpackage

// File: rtl/mux_out_edge_monitor_sat_counter.sv
// Saturating event counter with synchronous clear; count and sat update one cycle after inc/clr.
// No backpressure: every inc is taken, clear wins over the old value but not over a same-cycle inc.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         sat
);
   logic [W-1:0] base;
   logic [W-1:0] nxt;

   always_comb begin
      base = clr ? '0 : cnt;
      nxt  = base;
      if (inc && (base != '1)) nxt = base + W'(1);
   end

   // sat tracks the next count so it asserts in the same cycle the count hits max
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         sat <= 1'b0;
      end else begin
         cnt <= nxt;
         sat <= (nxt == '1);
      end
   end
endmodule

// File: rtl/mux_out_edge_monitor.sv
// Sync + debounce of upstream out_q, edge pulses, saturating counts and a valid/ready snapshot port.
// Level/pulse at edge STABLE_CYCLES+2; snapshot held while valid && !ready. Option: FALL_COUNT_EN.
module mux_out_edge_monitor
   import mux_mon_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
`ifdef FALL_COUNT_EN
   localparam int SNAP_W       = 2 * CNT_WIDTH
`else
   localparam int SNAP_W       = CNT_WIDTH
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_q,
   input  logic                 in_clear,
   input  logic                 in_snap_req,
   input  logic                 in_snap_ready,
   output logic                 out_level,
   output logic                 out_rise,
`ifdef FALL_COUNT_EN
   output logic                 out_fall,
`endif
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_sat,
   output logic                 out_snap_valid,
   output logic [SNAP_W-1:0]    out_snap_data
);
   localparam int SW = $clog2(STABLE_CYCLES);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

   logic          s1;
   logic          s2;
   deb_state_e    state;
   logic [SW-1:0] stab_cnt;
   logic [SNAP_W-1:0] snap_src;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= in_q;
         s2 <= s1;
      end
   end

   // A level change needs STABLE_CYCLES consecutive agreeing samples of s2
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= DEB_LOW;
         stab_cnt  <= '0;
         out_level <= 1'b0;
         out_rise  <= 1'b0;
`ifdef FALL_COUNT_EN
         out_fall  <= 1'b0;
`endif
      end else begin
         out_rise <= 1'b0;
`ifdef FALL_COUNT_EN
         out_fall <= 1'b0;
`endif
         case (state)
            DEB_LOW: begin
               if (s2) begin
                  state    <= DEB_CHK_HIGH;
                  stab_cnt <= SW'(1);
               end
            end
            DEB_CHK_HIGH: begin
               if (!s2) begin
                  state <= DEB_LOW;
               end else if (stab_cnt == STAB_LAST) begin
                  state     <= DEB_HIGH;
                  out_level <= 1'b1;
                  out_rise  <= 1'b1;
               end else begin
                  stab_cnt <= stab_cnt + SW'(1);
               end
            end
            DEB_HIGH: begin
               if (!s2) begin
                  state    <= DEB_CHK_LOW;
                  stab_cnt <= SW'(1);
               end
            end
            DEB_CHK_LOW: begin
               if (s2) begin
                  state <= DEB_HIGH;
               end else if (stab_cnt == STAB_LAST) begin
                  state     <= DEB_LOW;
                  out_level <= 1'b0;
`ifdef FALL_COUNT_EN
                  out_fall  <= 1'b1;
`endif
               end else begin
                  stab_cnt <= stab_cnt + SW'(1);
               end
            end
            default: state <= DEB_LOW;
         endcase
      end
   end

   sat_counter #(.W(CNT_WIDTH)) u_rise_cnt (
      .clk (clk),
      .rst (rst),
      .clr (in_clear),
      .inc (out_rise),
      .cnt (out_count),
      .sat (out_sat)
   );

`ifdef FALL_COUNT_EN
   logic [CNT_WIDTH-1:0] fall_count;
   logic                 fall_sat;

   sat_counter #(.W(CNT_WIDTH)) u_fall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (in_clear),
      .inc (out_fall),
      .cnt (fall_count),
      .sat (fall_sat)
   );

   assign snap_src = {fall_count, out_count};
`else
   assign snap_src = out_count;
`endif

   // A request is only honoured when the slot is free or being drained this cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         out_snap_valid <= 1'b0;
         out_snap_data  <= '0;
      end else if (!out_snap_valid) begin
         if (in_snap_req) begin
            out_snap_valid <= 1'b1;
            out_snap_data  <= snap_src;
         end
      end else if (in_snap_ready) begin
         if (in_snap_req) out_snap_data <= snap_src;
         else             out_snap_valid <= 1'b0;
      end
   end
endmodule
